rgb_breath_scheduler: RTL and testbench
=======================================

Name: rgb_breath_scheduler

Overview:
- Sequences one RGB breathing-LED channel through a colour schedule.
- Generates PWM duty, the rise/hold/fall/hold envelope and colour selection from the board switches and one push button.
- Replaces ad-hoc per-instance colour rotation with a single FSM-driven controller.
- Sits between the board switches/button and the active-low RGB LED pins; exports status for the seven-segment scan logic.

Parameters:
TICK_DIV, 1000, clock cycles per envelope tick per unit of speed setting
PWM_MAX, 255, PWM resolution; duty range 0..PWM_MAX
HOLD_STEPS, 64, ticks spent at peak and at trough (>=1)
DEBOUNCE, 50000, clock cycles button must be stable to register

Ports:
clk  input  1  system clock
real_rst  input  1  synchronous active-high reset
swx  input  4  speed; tick period = (swx+1)*TICK_DIV cycles
swy  input  4  swy[3]=0 auto cycle, swy[3]=1 manual; swy[2:0] manual colour mask {B,G,R}
btn  input  1  asynchronous push button, active-high, skip to next colour
led_r_n  output  1  red, active-low
led_g_n  output  1  green, active-low
led_b_n  output  1  blue, active-low
cur_color  output  3  current colour mask {B,G,R}
state_o  output  3  FSM state encoding
cycle_done  output  1  one-cycle pulse on every colour advance

Behaviour:
- Reset (real_rst=1 at posedge clk): state IDLE, duty=0, hold_cnt=0, prescaler=0, pwm_cnt=0, colour index 0, cur_color=0, led_*_n=1, cycle_done=0, debouncer and sync flops cleared.
- Reset asserted mid-breath: same values on the next edge; no partial pulse.
- Prescaler: counts 0..(swx+1)*TICK_DIV-1; tick is one cycle at wrap.
  - Compare uses >=, so lowering swx mid-count wraps on the next cycle.
  - Counter width 24 bits.
- PWM: pwm_cnt free-runs 0..PWM_MAX-1.
  - lit = (pwm_cnt < duty); duty=PWM_MAX means fully on, 0 means off.
  - led_x_n = ~(mask[x] & lit), registered, one-cycle latency.
  - In IDLE all outputs are 1.
- Enable: mode is off when swy[3]=1 and swy[2:0]=0; any other setting is enabled.
- Auto sequence by colour index 0..6: masks 001, 011, 010, 110, 100, 101, 111; index 6 wraps to 0.
- FSM, advancing only on tick unless noted:
  - IDLE -> RISE on the first clock the mode is enabled. Actions: duty=0, prescaler cleared, colour = auto index 0 (mask 001) or manual swy[2:0].
  - RISE: duty+1 per tick; on the tick where duty reaches PWM_MAX -> HOLD_HI with hold_cnt=0.
  - HOLD_HI: hold_cnt+1 per tick; on the tick with hold_cnt==HOLD_STEPS-1 -> FALL.
  - FALL: duty-1 per tick; on reaching 0 -> HOLD_LO with hold_cnt=0.
  - HOLD_LO: after HOLD_STEPS ticks -> RISE. Same edge: colour advances (auto: index+1; manual: re-latch swy[2:0]) and cycle_done=1.
  - Any state: mode becomes off -> IDLE next clock, duty=0, outputs off.
- Full colour period = 2*(PWM_MAX+HOLD_STEPS) ticks. Colour changes only at the trough, never mid-envelope.
- Button path:
  - 2-flop synchroniser, then a stability counter; the press registers after DEBOUNCE consecutive stable-high cycles.
  - Produces a single-cycle press pulse; release is also debounced; holding gives exactly one pulse.
- Press in auto mode outside IDLE: duty=0, state=RISE, colour index+1 (wraps), prescaler cleared, cycle_done=1.
- Press and tick on the same cycle: the press wins and the tick is discarded.
- Press in manual mode or IDLE: ignored.
- Switch auto->manual mid-breath: envelope continues; manual mask latched at next trough.
- Switch manual->auto: resumes at colour index 0 at the next trough.

Test Plan:
- Params TICK_DIV=2, PWM_MAX=4, HOLD_STEPS=2, DEBOUNCE=4; swx=0, swy=0000; release reset. Required: cur_color 001 on the first clock after reset, then cycle_done every 24 clocks, with colours 011, 010, 110, 100, 101, 111, 001.
- Same params, sample led_r_n over the HOLD_HI window. Required: constantly 0. Over HOLD_LO: constantly 1. At duty=2 in RISE: 0 for 2 of every 4 cycles.
- swx=3 -> tick every 8 clocks; colour period 96 clocks. Change swx 3->0 with prescaler at 6 -> tick on the next cycle.
- Button:
  - btn high 3 cycles -> no pulse.
  - btn high 10 cycles during FALL -> exactly one cycle_done; duty 0; colour 001->011; state RISE.
  - Press coincident with a tick -> duty stays 0.
- Mode changes:
  - swy=1101 manual -> cur_color 101 after the next trough.
  - swy=1000 -> IDLE next clock; all led_*_n=1.
  - Presses while in IDLE -> no change.
- Assert real_rst for 1 cycle mid-RISE -> all outputs at reset values on the next edge; restart from colour 001 after release.

Source files
------------

// File: rtl/rgb_breath_scheduler.sv
// ============================================================================
// rgb_breath_scheduler
// One breathing RGB channel: PWM duty envelope and colour schedule from switches/button.
// Revision: 1.0
// ============================================================================
`default_nettype none

module rgb_breath_scheduler #(
    parameter int TICK_DIV   = 1000,
    parameter int PWM_MAX    = 255,
    parameter int HOLD_STEPS = 64,
    parameter int DEBOUNCE   = 50000
) (
    input  logic       clk,
    input  logic       real_rst,
    input  logic [3:0] swx,
    input  logic [3:0] swy,
    input  logic       btn,
    output logic       led_r_n,
    output logic       led_g_n,
    output logic       led_b_n,
    output logic [2:0] cur_color,
    output logic [2:0] state_o,
    output logic       cycle_done
);

    localparam int DW = $clog2(PWM_MAX + 1);
    localparam int HW = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;
    localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

    localparam logic [DW-1:0] c_duty_top  = DW'(PWM_MAX - 1);
    localparam logic [DW-1:0] c_duty_one  = DW'(1);
    localparam logic [HW-1:0] c_hold_last = HW'(HOLD_STEPS - 1);
    localparam logic [HW-1:0] c_hold_one  = HW'(1);
    localparam logic [CW-1:0] c_db_last   = CW'(DEBOUNCE - 1);
    localparam logic [CW-1:0] c_db_one    = CW'(1);
    localparam logic [23:0]   c_tick_div  = 24'(TICK_DIV);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RISE    = 3'd1,
        S_HOLD_HI = 3'd2,
        S_FALL    = 3'd3,
        S_HOLD_LO = 3'd4
    } state_t;

    state_t          r_state, w_state_nx;
    logic [DW-1:0]   r_duty, w_duty_nx;
    logic [HW-1:0]   r_hold, w_hold_nx;
    logic [23:0]     r_presc, w_presc_nx;
    logic [2:0]      r_idx, w_idx_nx;
    logic [2:0]      r_color, w_color_nx;
    logic            r_man, w_man_nx;
    logic            r_done, w_done_nx;

    logic            r_sync1, r_sync2, r_db_level;
    logic [CW-1:0]   r_db_cnt;
    logic [DW-1:0]   r_pwm;
    logic            r_led_r_n, r_led_g_n, r_led_b_n;

    logic [23:0]     w_period;
    logic            w_tick;
    logic            w_en;
    logic            w_press;
    logic            w_lit;
    logic [2:0]      w_adv_idx;

    function automatic logic [2:0] f_auto_mask(input logic [2:0] idx);
        case (idx)
            3'd0:    f_auto_mask = 3'b001;
            3'd1:    f_auto_mask = 3'b011;
            3'd2:    f_auto_mask = 3'b010;
            3'd3:    f_auto_mask = 3'b110;
            3'd4:    f_auto_mask = 3'b100;
            3'd5:    f_auto_mask = 3'b101;
            default: f_auto_mask = 3'b111;
        endcase
    endfunction

    assign w_period = ({20'd0, swx} + 24'd1) * c_tick_div;
    assign w_tick   = (r_presc >= (w_period - 24'd1));
    assign w_en     = !(swy[3] && (swy[2:0] == 3'b000));
    assign w_press  = r_sync2 && !r_db_level && (r_db_cnt == c_db_last);
    assign w_lit    = (r_pwm < r_duty);
    // Returning from manual restarts the auto rotation at its first colour.
    assign w_adv_idx = r_man ? 3'd0 : ((r_idx == 3'd6) ? 3'd0 : r_idx + 3'd1);

    always_ff @(posedge clk) begin
        if (real_rst) begin
            r_state <= S_IDLE;
            r_duty  <= '0;
            r_hold  <= '0;
            r_presc <= '0;
            r_idx   <= '0;
            r_color <= '0;
            r_man   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_duty  <= w_duty_nx;
            r_hold  <= w_hold_nx;
            r_presc <= w_presc_nx;
            r_idx   <= w_idx_nx;
            r_color <= w_color_nx;
            r_man   <= w_man_nx;
            r_done  <= w_done_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_duty_nx  = r_duty;
        w_hold_nx  = r_hold;
        w_presc_nx = w_tick ? 24'd0 : r_presc + 24'd1;
        w_idx_nx   = r_idx;
        w_color_nx = r_color;
        w_man_nx   = r_man;
        w_done_nx  = 1'b0;

        if (!w_en) begin
            w_state_nx = S_IDLE;
            w_duty_nx  = '0;
            w_hold_nx  = '0;
            w_presc_nx = '0;
            w_color_nx = 3'b000;
        end else if (r_state == S_IDLE) begin
            w_state_nx = S_RISE;
            w_duty_nx  = '0;
            w_hold_nx  = '0;
            w_presc_nx = '0;
            w_idx_nx   = 3'd0;
            w_man_nx   = swy[3];
            w_color_nx = swy[3] ? swy[2:0] : 3'b001;
        end else if (w_press && !swy[3]) begin
            // Press overrides any tick landing on the same cycle.
            w_state_nx = S_RISE;
            w_duty_nx  = '0;
            w_hold_nx  = '0;
            w_presc_nx = '0;
            w_idx_nx   = w_adv_idx;
            w_color_nx = f_auto_mask(w_adv_idx);
            w_man_nx   = 1'b0;
            w_done_nx  = 1'b1;
        end else if (w_tick) begin
            case (r_state)
                S_RISE: begin
                    w_duty_nx = r_duty + c_duty_one;
                    if (r_duty == c_duty_top) begin
                        w_state_nx = S_HOLD_HI;
                        w_hold_nx  = '0;
                    end
                end
                S_HOLD_HI: begin
                    if (r_hold == c_hold_last) begin
                        w_state_nx = S_FALL;
                        w_hold_nx  = '0;
                    end else begin
                        w_hold_nx = r_hold + c_hold_one;
                    end
                end
                S_FALL: begin
                    w_duty_nx = r_duty - c_duty_one;
                    if (r_duty == c_duty_one) begin
                        w_state_nx = S_HOLD_LO;
                        w_hold_nx  = '0;
                    end
                end
                S_HOLD_LO: begin
                    if (r_hold == c_hold_last) begin
                        w_state_nx = S_RISE;
                        w_hold_nx  = '0;
                        w_done_nx  = 1'b1;
                        if (swy[3]) begin
                            w_color_nx = swy[2:0];
                            w_man_nx   = 1'b1;
                        end else begin
                            w_idx_nx   = w_adv_idx;
                            w_color_nx = f_auto_mask(w_adv_idx);
                            w_man_nx   = 1'b0;
                        end
                    end else begin
                        w_hold_nx = r_hold + c_hold_one;
                    end
                end
                default: begin
                    w_state_nx = S_IDLE;
                    w_duty_nx  = '0;
                end
            endcase
        end
    end

    // Button: two-flop synchroniser, then symmetric press/release debounce.
    always_ff @(posedge clk) begin
        if (real_rst) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_db_level <= 1'b0;
            r_db_cnt   <= '0;
        end else begin
            r_sync1 <= btn;
            r_sync2 <= r_sync1;
            if (r_sync2 != r_db_level) begin
                if (r_db_cnt == c_db_last) begin
                    r_db_level <= r_sync2;
                    r_db_cnt   <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + c_db_one;
                end
            end else begin
                r_db_cnt <= '0;
            end
        end
    end

    // LEDs blank on the same edge the FSM drops into IDLE.
    always_ff @(posedge clk) begin
        if (real_rst) begin
            r_pwm     <= '0;
            r_led_r_n <= 1'b1;
            r_led_g_n <= 1'b1;
            r_led_b_n <= 1'b1;
        end else begin
            r_pwm <= (r_pwm >= c_duty_top) ? '0 : r_pwm + c_duty_one;
            if (w_state_nx == S_IDLE) begin
                r_led_r_n <= 1'b1;
                r_led_g_n <= 1'b1;
                r_led_b_n <= 1'b1;
            end else begin
                r_led_r_n <= ~(r_color[0] & w_lit);
                r_led_g_n <= ~(r_color[1] & w_lit);
                r_led_b_n <= ~(r_color[2] & w_lit);
            end
        end
    end

    assign led_r_n    = r_led_r_n;
    assign led_g_n    = r_led_g_n;
    assign led_b_n    = r_led_b_n;
    assign cur_color  = r_color;
    assign state_o    = r_state;
    assign cycle_done = r_done;

endmodule

`default_nettype wire

// File: tb/tb_rgb_breath_scheduler.sv
// ============================================================================
// tb_rgb_breath_scheduler
// Directed checks of the breathing scheduler with small parameters.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_rgb_breath_scheduler;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_RISE = 3'd1;
    localparam logic [2:0] ST_HH   = 3'd2;
    localparam logic [2:0] ST_FALL = 3'd3;
    localparam logic [2:0] ST_HL   = 3'd4;

    logic       clk = 1'b0;
    logic       real_rst;
    logic [3:0] swx;
    logic [3:0] swy;
    logic       btn;
    logic       led_r_n, led_g_n, led_b_n;
    logic [2:0] cur_color;
    logic [2:0] state_o;
    logic       cycle_done;

    int total = 0;
    int bad   = 0;
    int edge_no;

    always #5 clk = ~clk;

    rgb_breath_scheduler #(
        .TICK_DIV  (2),
        .PWM_MAX   (4),
        .HOLD_STEPS(2),
        .DEBOUNCE  (4)
    ) dut (
        .clk       (clk),
        .real_rst  (real_rst),
        .swx       (swx),
        .swy       (swy),
        .btn       (btn),
        .led_r_n   (led_r_n),
        .led_g_n   (led_g_n),
        .led_b_n   (led_b_n),
        .cur_color (cur_color),
        .state_o   (state_o),
        .cycle_done(cycle_done)
    );

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            edge_no++;
        end
    endtask

    task automatic step_to(input int t);
        while (edge_no < t) step(1);
    endtask

    // Leaves reset released; the next step() lands on edge 0.
    task automatic do_reset(input logic [3:0] sx, input logic [3:0] sy);
        real_rst = 1'b1;
        btn      = 1'b0;
        swx      = sx;
        swy      = sy;
        edge_no  = 0;
        step(2);
        real_rst = 1'b0;
        edge_no  = -1;
    endtask

    task automatic test_reset;
        do_reset(4'd0, 4'b0000);
        real_rst = 1'b1;
        step(1);
        total++; if (state_o !== ST_IDLE) begin bad++; $display("FAIL reset_state got=%0d exp=%0d", state_o, ST_IDLE); end
        total++; if (cur_color !== 3'b000) begin bad++; $display("FAIL reset_color got=%b exp=000", cur_color); end
        total++; if ({led_b_n, led_g_n, led_r_n} !== 3'b111) begin bad++; $display("FAIL reset_leds got=%b exp=111", {led_b_n, led_g_n, led_r_n}); end
        total++; if (cycle_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", cycle_done); end
        real_rst = 1'b0;
        edge_no  = -1;
        step(1);
        total++; if (cur_color !== 3'b001) begin bad++; $display("FAIL first_color got=%b exp=001", cur_color); end
        total++; if (state_o !== ST_RISE) begin bad++; $display("FAIL first_state got=%0d exp=%0d", state_o, ST_RISE); end
    endtask

    task automatic test_auto_sequence;
        logic [2:0] exp_col [7] = '{3'b011, 3'b010, 3'b110, 3'b100, 3'b101, 3'b111, 3'b001};
        step_to(8);
        total++; if (state_o !== ST_HH) begin bad++; $display("FAIL env_hold_hi got=%0d exp=%0d", state_o, ST_HH); end
        step_to(12);
        total++; if (state_o !== ST_FALL) begin bad++; $display("FAIL env_fall got=%0d exp=%0d", state_o, ST_FALL); end
        step_to(20);
        total++; if (state_o !== ST_HL) begin bad++; $display("FAIL env_hold_lo got=%0d exp=%0d", state_o, ST_HL); end
        for (int k = 0; k < 7; k++) begin
            step_to(24 * (k + 1) - 1);
            total++; if (cycle_done !== 1'b0) begin bad++; $display("FAIL seq_pre_done[%0d] got=%b exp=0", k, cycle_done); end
            step(1);
            total++; if (cycle_done !== 1'b1) begin bad++; $display("FAIL seq_done[%0d] got=%b exp=1", k, cycle_done); end
            total++; if (cur_color !== exp_col[k]) begin bad++; $display("FAIL seq_color[%0d] got=%b exp=%b", k, cur_color, exp_col[k]); end
        end
    endtask

    task automatic test_led_envelope;
        do_reset(4'd0, 4'b0000);
        for (int e = 9; e <= 12; e++) begin
            step_to(e);
            total++; if ({led_b_n, led_g_n, led_r_n} !== 3'b110) begin bad++; $display("FAIL led_hold_hi@%0d got=%b exp=110", e, {led_b_n, led_g_n, led_r_n}); end
        end
        for (int e = 21; e <= 24; e++) begin
            step_to(e);
            total++; if (led_r_n !== 1'b1) begin bad++; $display("FAIL led_hold_lo@%0d got=%b exp=1", e, led_r_n); end
        end
    endtask

    task automatic test_pwm_and_speed;
        int zeros;
        do_reset(4'd3, 4'b0000);
        step_to(17);
        zeros = 0;
        for (int i = 0; i < 4; i++) begin
            step(1);
            if (led_r_n === 1'b0) zeros++;
        end
        total++; if (zeros !== 2) begin bad++; $display("FAIL pwm_half_duty got=%0d exp=2", zeros); end
        step_to(95);
        total++; if (cycle_done !== 1'b0) begin bad++; $display("FAIL slow_pre_done got=%b exp=0", cycle_done); end
        step_to(96);
        total++; if (cycle_done !== 1'b1) begin bad++; $display("FAIL slow_done got=%b exp=1", cycle_done); end
        total++; if (cur_color !== 3'b011) begin bad++; $display("FAIL slow_color got=%b exp=011", cur_color); end
    endtask

    task automatic test_speed_change;
        do_reset(4'd3, 4'b0000);
        step_to(6);
        swx = 4'd0;
        step_to(12);
        total++; if (state_o !== ST_RISE) begin bad++; $display("FAIL swx_drop_rise got=%0d exp=%0d", state_o, ST_RISE); end
        step_to(13);
        total++; if (state_o !== ST_HH) begin bad++; $display("FAIL swx_drop_hh got=%0d exp=%0d", state_o, ST_HH); end
    endtask

    task automatic test_button;
        int pulses;
        logic seen;
        do_reset(4'd0, 4'b0000);
        step_to(0);
        btn = 1'b1;
        step(3);
        btn  = 1'b0;
        seen = 1'b0;
        for (int e = 4; e <= 9; e++) begin
            step_to(e);
            if (cycle_done === 1'b1) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL short_press_pulse got=%b exp=0", seen); end
        total++; if (state_o !== ST_HH) begin bad++; $display("FAIL short_press_state got=%0d exp=%0d", state_o, ST_HH); end
        btn    = 1'b1;
        pulses = 0;
        for (int e = 10; e <= 49; e++) begin
            step_to(e);
            if (e <= 38 && cycle_done === 1'b1) pulses++;
            if (e == 19) btn = 1'b0;
            if (e == 35) btn = 1'b1;
            if (e == 41) btn = 1'b0;
            if (e == 14) begin
                total++; if (state_o !== ST_FALL) begin bad++; $display("FAIL press_pre_state got=%0d exp=%0d", state_o, ST_FALL); end
            end
            if (e == 15) begin
                total++; if (cycle_done !== 1'b1) begin bad++; $display("FAIL press_done got=%b exp=1", cycle_done); end
                total++; if (state_o !== ST_RISE) begin bad++; $display("FAIL press_state got=%0d exp=%0d", state_o, ST_RISE); end
                total++; if (cur_color !== 3'b011) begin bad++; $display("FAIL press_color got=%b exp=011", cur_color); end
            end
            if (e == 16) begin
                total++; if ({led_b_n, led_g_n, led_r_n} !== 3'b111) begin bad++; $display("FAIL press_duty0 got=%b exp=111", {led_b_n, led_g_n, led_r_n}); end
            end
            if (e == 22) begin
                total++; if (state_o !== ST_RISE) begin bad++; $display("FAIL press_rise_len got=%0d exp=%0d", state_o, ST_RISE); end
            end
            if (e == 23) begin
                total++; if (state_o !== ST_HH) begin bad++; $display("FAIL press_rise_end got=%0d exp=%0d", state_o, ST_HH); end
            end
            if (e == 39) begin
                total++; if (cur_color !== 3'b010 || cycle_done !== 1'b1) begin bad++; $display("FAIL post_press_trough got=%b/%b exp=010/1", cur_color, cycle_done); end
            end
            if (e == 41) begin
                total++; if (cur_color !== 3'b110 || cycle_done !== 1'b1) begin bad++; $display("FAIL tick_press got=%b/%b exp=110/1", cur_color, cycle_done); end
            end
            if (e == 47) begin
                total++; if (state_o !== ST_RISE) begin bad++; $display("FAIL tick_press_rise got=%0d exp=%0d", state_o, ST_RISE); end
            end
            if (e == 49) begin
                total++; if (state_o !== ST_HH) begin bad++; $display("FAIL tick_press_hh got=%0d exp=%0d", state_o, ST_HH); end
            end
        end
        total++; if (pulses !== 1) begin bad++; $display("FAIL long_press_pulses got=%0d exp=1", pulses); end
    endtask

    task automatic test_mode;
        logic moved;
        do_reset(4'd0, 4'b0000);
        step_to(2);
        swy = 4'b1101;
        step_to(23);
        total++; if (cur_color !== 3'b001) begin bad++; $display("FAIL manual_mid got=%b exp=001", cur_color); end
        step_to(24);
        total++; if (cur_color !== 3'b101 || cycle_done !== 1'b1) begin bad++; $display("FAIL manual_latch got=%b/%b exp=101/1", cur_color, cycle_done); end
        step_to(26);
        swy = 4'b0000;
        step_to(47);
        total++; if (cur_color !== 3'b101) begin bad++; $display("FAIL auto_mid got=%b exp=101", cur_color); end
        step_to(48);
        total++; if (cur_color !== 3'b001 || cycle_done !== 1'b1) begin bad++; $display("FAIL auto_resume got=%b/%b exp=001/1", cur_color, cycle_done); end
        step_to(50);
        swy = 4'b1000;
        step_to(51);
        total++; if (state_o !== ST_IDLE) begin bad++; $display("FAIL off_state got=%0d exp=%0d", state_o, ST_IDLE); end
        total++; if ({led_b_n, led_g_n, led_r_n} !== 3'b111) begin bad++; $display("FAIL off_leds got=%b exp=111", {led_b_n, led_g_n, led_r_n}); end
        btn   = 1'b1;
        moved = 1'b0;
        for (int e = 52; e <= 70; e++) begin
            step_to(e);
            if (e == 61) btn = 1'b0;
            if (cycle_done !== 1'b0 || state_o !== ST_IDLE || {led_b_n, led_g_n, led_r_n} !== 3'b111) moved = 1'b1;
        end
        total++; if (moved !== 1'b0) begin bad++; $display("FAIL idle_press got=%b exp=0", moved); end
    endtask

    task automatic test_reset_mid;
        do_reset(4'd0, 4'b0000);
        step_to(5);
        real_rst = 1'b1;
        step(1);
        total++; if (state_o !== ST_IDLE || cur_color !== 3'b000) begin bad++; $display("FAIL midrst_state got=%0d/%b exp=0/000", state_o, cur_color); end
        total++; if ({led_b_n, led_g_n, led_r_n} !== 3'b111 || cycle_done !== 1'b0) begin bad++; $display("FAIL midrst_outs got=%b/%b exp=111/0", {led_b_n, led_g_n, led_r_n}, cycle_done); end
        real_rst = 1'b0;
        edge_no  = -1;
        step(1);
        total++; if (cur_color !== 3'b001 || state_o !== ST_RISE) begin bad++; $display("FAIL midrst_restart got=%b/%0d exp=001/1", cur_color, state_o); end
        step_to(24);
        total++; if (cur_color !== 3'b011 || cycle_done !== 1'b1) begin bad++; $display("FAIL midrst_period got=%b/%b exp=011/1", cur_color, cycle_done); end
    endtask

    initial begin
        real_rst = 1'b1;
        swx      = 4'd0;
        swy      = 4'b0000;
        btn      = 1'b0;
        edge_no  = 0;
        test_reset;
        test_auto_sequence;
        test_led_envelope;
        test_pwm_and_speed;
        test_speed_change;
        test_button;
        test_mode;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
